param_cache: RTL

Parametrised, set-associative, write-back / write-allocate cache that replaces the fixed `mem_cache` between the datapath and the word-addressed backing memory. It is one word per line, with configurable set count and 1- or 2-way associativity, plus true-LRU replacement for the 2-way case. It adds a `ready`/`hit` completion handshake toward the requester and a `memRead`/`memWrite`/`memAck` handshake toward memory, so that misses and dirty evictions stall cleanly.

---
 rtl/param_cache.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/param_cache.sv
// rtl/param_cache.sv - set-associative write-back/write-allocate cache, one word per line
// 1- or 2-way, true-LRU, with ready/hit toward the requester and a read/write/ack memory handshake.
module param_cache #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 6,
   parameter int WAYS    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData,
   output logic              ready,
   output logic              hit,
   output logic              memRead,
   output logic              memWrite,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWriteData,
   input  logic [DATA_W-1:0] memReadData,
   input  logic              memAck
);
   localparam int SETS  = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
   state_t state, state_next;

   // Storage is always declared two ways wide; way 1 is simply never used when WAYS == 1.
   logic [SETS-1:0]   valid [2];
   logic [SETS-1:0]   dirty [2];
   logic [SETS-1:0]   lru;
   logic [TAG_W-1:0]  tag_mem  [2][SETS];
   logic [DATA_W-1:0] data_mem [2][SETS];

   logic               op_write, after_fill, victim;
   logic [ADDR_W-1:0]  req_addr;
   logic [DATA_W-1:0]  req_data;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   req_tag;
   logic               hit0, hit1, lookup_hit, hit_way, miss_victim, victim_dirty;

   assign idx     = req_addr[INDEX_W-1:0];
   assign req_tag = req_addr[ADDR_W-1:INDEX_W];

   always_comb begin
      hit0        = valid[0][idx] && (tag_mem[0][idx] == req_tag);
      hit1        = (WAYS == 2) && valid[1][idx] && (tag_mem[1][idx] == req_tag);
      lookup_hit  = hit0 || hit1;
      hit_way     = hit1;
      miss_victim = 1'b0;
      if (WAYS == 2) begin
         if (!valid[0][idx])      miss_victim = 1'b0;
         else if (!valid[1][idx]) miss_victim = 1'b1;
         else                     miss_victim = lru[idx];
      end
      victim_dirty = valid[miss_victim][idx] && dirty[miss_victim][idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (read || write) state_next = COMPARE;
         COMPARE:   state_next = lookup_hit ? IDLE : (victim_dirty ? WRITEBACK : FILL);
         WRITEBACK: if (memAck) state_next = FILL;
         FILL:      if (memAck) state_next = COMPARE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid[0]     <= '0;
         valid[1]     <= '0;
         dirty[0]     <= '0;
         dirty[1]     <= '0;
         lru          <= '0;
         op_write     <= 1'b0;
         after_fill   <= 1'b0;
         victim       <= 1'b0;
         req_addr     <= '0;
         req_data     <= '0;
         readData     <= '0;
         ready        <= 1'b0;
         hit          <= 1'b0;
         memRead      <= 1'b0;
         memWrite     <= 1'b0;
         memAddr      <= '0;
         memWriteData <= '0;
      end else begin
         ready <= 1'b0;
         hit   <= 1'b0;
         case (state)
            IDLE: begin
               if (read || write) begin
                  op_write   <= write;
                  req_addr   <= addr;
                  req_data   <= writeData;
                  after_fill <= 1'b0;
               end
            end
            COMPARE: begin
               if (lookup_hit) begin
                  if (op_write) dirty[hit_way][idx] <= 1'b1;
                  else          readData <= data_mem[hit_way][idx];
                  if (WAYS == 2) lru[idx] <= ~hit_way;
                  ready <= 1'b1;
                  hit   <= ~after_fill;
               end else begin
                  victim <= miss_victim;
                  if (victim_dirty) begin
                     memWrite     <= 1'b1;
                     memAddr      <= {tag_mem[miss_victim][idx], idx};
                     memWriteData <= data_mem[miss_victim][idx];
                  end else begin
                     memRead <= 1'b1;
                     memAddr <= req_addr;
                  end
               end
            end
            WRITEBACK: begin
               if (memAck) begin
                  dirty[victim][idx] <= 1'b0;
                  memWrite           <= 1'b0;
                  memRead            <= 1'b1;
                  memAddr            <= req_addr;
               end
            end
            FILL: begin
               if (memAck) begin
                  valid[victim][idx] <= 1'b1;
                  dirty[victim][idx] <= 1'b0;
                  memRead            <= 1'b0;
                  after_fill         <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (state == COMPARE && lookup_hit && op_write)
         data_mem[hit_way][idx] <= req_data;
      if (state == FILL && memAck) begin
         data_mem[victim][idx] <= memReadData;
         tag_mem[victim][idx]  <= req_tag;
      end
   end
endmodule
